// File: rtl/draw_rect_ctl_pkg.sv
// rtl/draw_rect_ctl_pkg.sv - shared types, widths and helpers for the rectangle motion controller
//
// Contents:
//   state_t            controller state {IDLE, FALL, BOTTOM}
//   DEF_SCREEN_WIDTH   default visible pixels per line
//   DEF_SCREEN_HEIGHT  default visible lines
//   FRAC_W             fraction bits of the 12.8 fixed-point Y accumulator
//   POS_W / ACC_W / VEL_W  coordinate, accumulator and velocity widths
//   clamp_pos()        saturate a coordinate to an upper limit
package rect_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FALL,
        BOTTOM
    } state_t;

    localparam int DEF_SCREEN_WIDTH  = 800;
    localparam int DEF_SCREEN_HEIGHT = 600;

    localparam int FRAC_W = 8;
    localparam int POS_W  = 12;
    localparam int ACC_W  = POS_W + FRAC_W;
    localparam int VEL_W  = 16;

    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] pos,
                                                   input logic [POS_W-1:0] lim);
        return (pos > lim) ? lim : pos;
    endfunction

endpackage

// File: rtl/draw_rect_ctl_if.sv
// rtl/draw_rect_ctl_if.sv - mouse-in / rectangle-out bundle of the rectangle motion controller
//
// Signals:
//   mouse_xpos  12  mouse X, pclk domain
//   mouse_ypos  12  mouse Y, pclk domain
//   mouse_left   1  left button, asynchronous to pclk
//   xpos        12  rectangle X to draw_rect
//   ypos        12  rectangle Y to draw_rect
//   falling      1  high while the rectangle is falling
// Modports:
//   master  drives the mouse side, observes the rectangle side
//   slave   the controller: consumes the mouse side, drives the rectangle side
interface draw_rect_ctl_if;
    import rect_ctl_pkg::*;

    logic [POS_W-1:0] mouse_xpos;
    logic [POS_W-1:0] mouse_ypos;
    logic             mouse_left;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic             falling;

    modport master (
        output mouse_xpos,
        output mouse_ypos,
        output mouse_left,
        input  xpos,
        input  ypos,
        input  falling
    );

    modport slave (
        input  mouse_xpos,
        input  mouse_ypos,
        input  mouse_left,
        output xpos,
        output ypos,
        output falling
    );

endinterface

// File: rtl/draw_rect_ctl_tick_gen.sv
// rtl/draw_rect_ctl_tick_gen.sv - free-running divider producing a one-cycle motion tick
//
// Parameters:
//   TICK_DIV  pclk cycles per tick
// Ports:
//   pclk  in   clock
//   rst   in   synchronous active-high reset, clears the counter
//   tick  out  high for the single cycle in which the counter is TICK_DIV-1
module tick_gen #(
    parameter int TICK_DIV = 40_000
) (
    input  logic pclk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/draw_rect_ctl.sv
// rtl/draw_rect_ctl.sv - rectangle motion controller: mouse tracking, gravity fall, rest at bottom
//
// Parameters:
//   SCREEN_WIDTH, SCREEN_HEIGHT  visible area
//   RECT_WIDTH, RECT_HEIGHT      rectangle size
//   TICK_DIV                     pclk cycles per motion tick
//   ACCEL                        velocity increment per tick, 1/256 px/tick
//   VMAX                         velocity ceiling, 1/256 px/tick
// Ports:
//   pclk  in   pixel clock, the only clock
//   rst   in   synchronous active-high reset
//   bus   slave modport of draw_rect_ctl_if (mouse in, rectangle position and falling out)
module draw_rect_ctl
    import rect_ctl_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int RECT_WIDTH    = 48,
    parameter int RECT_HEIGHT   = 64,
    parameter int TICK_DIV      = 40_000,
    parameter int ACCEL         = 16,
    parameter int VMAX          = 2048
) (
    input  logic            pclk,
    input  logic            rst,
    draw_rect_ctl_if.slave  bus
);

    localparam logic [POS_W-1:0] XMAX = POS_W'(SCREEN_WIDTH - RECT_WIDTH);
    localparam logic [POS_W-1:0] YMAX = POS_W'(SCREEN_HEIGHT - RECT_HEIGHT);

    // Button synchronizer and edge detector; click is one cycle per press.
    logic btn_meta;
    logic btn_sync;
    logic btn_prev;
    logic click;

    always_ff @(posedge pclk) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_meta <= bus.mouse_left;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
        end
    end

    assign click = btn_sync & ~btn_prev;

    logic tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .pclk (pclk),
        .rst  (rst),
        .tick (tick)
    );

    logic [POS_W-1:0] mouse_x_clamped;
    logic [POS_W-1:0] mouse_y_clamped;

    assign mouse_x_clamped = clamp_pos(bus.mouse_xpos, XMAX);
    assign mouse_y_clamped = clamp_pos(bus.mouse_ypos, YMAX);

    state_t           state_q, state_d;
    logic [POS_W-1:0] xpos_q,  xpos_d;
    logic [POS_W-1:0] ypos_q,  ypos_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [VEL_W-1:0] vel_q,   vel_d;

    // One gravity step: saturating velocity, then position in 12.8 fixed point.
    // The sum is one bit wider so the VMAX comparison cannot be fooled by wrap.
    logic [VEL_W:0]   vel_sum;
    logic [VEL_W-1:0] vel_step;
    logic [ACC_W-1:0] acc_step;

    assign vel_sum  = {1'b0, vel_q} + (VEL_W+1)'(ACCEL);
    assign vel_step = (vel_sum > (VEL_W+1)'(VMAX)) ? VEL_W'(VMAX) : vel_sum[VEL_W-1:0];
    assign acc_step = acc_q + {{(ACC_W-VEL_W){1'b0}}, vel_step};

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= IDLE;
            xpos_q  <= '0;
            ypos_q  <= '0;
            acc_q   <= '0;
            vel_q   <= '0;
        end else begin
            state_q <= state_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            acc_q   <= acc_d;
            vel_q   <= vel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        acc_d   = acc_q;
        vel_d   = vel_q;

        case (state_q)
            IDLE: begin
                xpos_d = mouse_x_clamped;
                ypos_d = mouse_y_clamped;
                if (click) begin
                    acc_d   = {mouse_y_clamped, {FRAC_W{1'b0}}};
                    vel_d   = '0;
                    // Already resting on the bottom edge: nothing to fall.
                    state_d = (mouse_y_clamped == YMAX) ? BOTTOM : FALL;
                end
            end

            FALL: begin
                if (tick) begin
                    if (acc_step[ACC_W-1:FRAC_W] >= YMAX) begin
                        ypos_d  = YMAX;
                        acc_d   = {YMAX, {FRAC_W{1'b0}}};
                        vel_d   = '0;
                        state_d = BOTTOM;
                    end else begin
                        ypos_d = acc_step[ACC_W-1:FRAC_W];
                        acc_d  = acc_step;
                        vel_d  = vel_step;
                    end
                end
            end

            BOTTOM: begin
                ypos_d = YMAX;
                if (click) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.xpos    = xpos_q;
    assign bus.ypos    = ypos_q;
    assign bus.falling = (state_q == FALL);

endmodule

// File: tb/tb_draw_rect_ctl.sv
// tb/tb_draw_rect_ctl.sv - self-checking bench for draw_rect_ctl
module tb_draw_rect_ctl;

    typedef struct {
        string       tag;
        logic [11:0] x;
        logic [11:0] y;
        logic        f;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    int total = 0;
    int bad   = 0;

    exp_t sb[$];

    draw_rect_ctl_if bus ();

    draw_rect_ctl #(
        .SCREEN_WIDTH  (800),
        .SCREEN_HEIGHT (600),
        .RECT_WIDTH    (48),
        .RECT_HEIGHT   (64),
        .TICK_DIV      (4),
        .ACCEL         (256),
        .VMAX          (4096)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic push(input string tag, input int x, input int y, input bit f);
        exp_t e;
        e.tag = tag;
        e.x   = 12'(x);
        e.y   = 12'(y);
        e.f   = f;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected>0");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            assert ({bus.xpos, bus.ypos, bus.falling} === {e.x, e.y, e.f}) else begin
                bad++;
                $error("FAIL %s observed x=%0d y=%0d f=%0b expected x=%0d y=%0d f=%0b",
                       e.tag, bus.xpos, bus.ypos, bus.falling, e.x, e.y, e.f);
            end
        end
    endtask

    task automatic expect_now(input string tag, input int x, input int y, input bit f);
        push(tag, x, y, f);
        check_out();
    endtask

    task automatic cmp_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_mouse(input int x, input int y);
        bus.mouse_xpos = 12'(x);
        bus.mouse_ypos = 12'(y);
    endtask

    // Waits for each ypos step of a fall and checks it against the queued
    // expectations; steps after the first must be exactly one tick apart.
    task automatic fall_steps(input int count);
        logic [11:0] prev;
        int          n;
        for (int i = 0; i < count; i++) begin
            prev = bus.ypos;
            n    = 0;
            while (bus.ypos === prev && n < 8) begin
                cyc(1);
                n++;
            end
            total++;
            assert (bus.ypos !== prev) else begin
                bad++;
                $error("FAIL fall_step_timeout observed=%0d expected=change", bus.ypos);
            end
            if (i == 0) begin
                total++;
                assert (n >= 1 && n <= 4) else begin
                    bad++;
                    $error("FAIL first_step_delay observed=%0d expected=1..4", n);
                end
            end else begin
                cmp_int("tick_period", n, 4);
            end
            check_out();
        end
    endtask

    initial begin
        bit seen_fall;
        int fall_y[8];

        fall_y = '{501, 503, 506, 510, 515, 521, 528, 536};

        bus.mouse_left = 1'b0;
        set_mouse(0, 0);
        rst = 1'b1;
        cyc(2);
        expect_now("reset_state", 0, 0, 0);

        rst = 1'b0;
        set_mouse(100, 200);
        cyc(1);
        expect_now("idle_track", 100, 200, 0);

        rst = 1'b1;
        cyc(1);
        expect_now("reset_idle", 0, 0, 0);
        rst = 1'b0;
        cyc(1);
        expect_now("idle_after_reset", 100, 200, 0);

        set_mouse(900, 700);
        cyc(1);
        expect_now("idle_clamp", 752, 536, 0);

        set_mouse(300, 500);
        cyc(1);
        expect_now("idle_pre_click", 300, 500, 0);

        // Press and keep holding through the whole fall and into BOTTOM.
        bus.mouse_left = 1'b1;
        cyc(2);
        expect_now("click_n1", 300, 500, 0);
        cyc(1);
        expect_now("click_n2_fall", 300, 500, 1);
        set_mouse(50, 100);
        for (int i = 0; i < 8; i++) begin
            push("fall_step", 300, fall_y[i], fall_y[i] != 536);
        end
        fall_steps(8);

        cyc(20);
        expect_now("bottom_held_button", 300, 536, 0);

        bus.mouse_left = 1'b0;
        cyc(3);
        bus.mouse_left = 1'b1;
        cyc(3);
        expect_now("bottom_release_edge", 300, 536, 0);
        cyc(1);
        expect_now("idle_resume", 50, 100, 0);

        bus.mouse_left = 1'b0;
        cyc(3);
        set_mouse(200, 600);
        cyc(1);
        bus.mouse_left = 1'b1;
        cyc(3);
        expect_now("direct_bottom", 200, 536, 0);
        set_mouse(10, 10);
        seen_fall = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (bus.falling) seen_fall = 1'b1;
        end
        cmp_int("direct_bottom_no_fall", int'(seen_fall), 0);
        expect_now("direct_bottom_hold", 200, 536, 0);
        bus.mouse_left = 1'b0;
        cyc(3);
        bus.mouse_left = 1'b1;
        cyc(4);
        expect_now("direct_bottom_release", 10, 10, 0);
        bus.mouse_left = 1'b0;

        set_mouse(300, 500);
        cyc(3);
        bus.mouse_left = 1'b1;
        cyc(3);
        expect_now("refall_start", 300, 500, 1);
        for (int i = 0; i < 4; i++) begin
            push("refall_step", 300, fall_y[i], 1);
        end
        fall_steps(4);

        rst = 1'b1;
        bus.mouse_left = 1'b0;
        cyc(1);
        expect_now("reset_mid_fall", 0, 0, 0);
        rst = 1'b0;
        cyc(1);
        expect_now("after_mid_fall_reset", 300, 500, 0);

        bus.mouse_left = 1'b1;
        cyc(3);
        expect_now("restart_fall", 300, 500, 1);
        push("restart_first_step", 300, 501, 1);
        fall_steps(1);
        bus.mouse_left = 1'b0;

        cmp_int("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
